// File: rtl/uart_pkg.sv
// uart_pkg: shared UART receive types, default oversampling and sample-index constants
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  localparam int OVERSAMPLE_DEF = 16;
  localparam int SAMPLE_MID = OVERSAMPLE_DEF / 2;
  localparam int SAMPLE_DEC = SAMPLE_MID + 1;
  function automatic int dec_idx(input int os);
    return os / 2 + 1;
  endfunction
endpackage

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: tick counter, mid-bit sample history and 2-of-3 vote; ports clk/rst, rx_tick, clr (hold counter at 0), rx_in -> decide, bit_end strobes and voted bit_val
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic rx_tick,
  input  logic clr,
  input  logic rx_in,
  output logic decide,
  output logic bit_end,
  output logic bit_val
);
  localparam int CW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] DEC = CW'(dec_idx(OVERSAMPLE));
  localparam logic [CW-1:0] LAST = CW'(OVERSAMPLE - 1);
  logic [CW-1:0] tick_cnt;
  logic [1:0] hist;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tick_cnt <= '0;
      hist <= '0;
    end else if (rx_tick) begin
      tick_cnt <= (clr || tick_cnt == LAST) ? '0 : tick_cnt + CW'(1);
      hist <= {hist[0], rx_in};
    end
  end
  assign decide = rx_tick & ~clr & (tick_cnt == DEC);
  assign bit_end = rx_tick & ~clr & (tick_cnt == LAST);
  assign bit_val = (hist[1] & hist[0]) | (hist[1] & rx_in) | (hist[0] & rx_in);
endmodule

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: UART receive sequencer; ports clk/rst, rx_tick, rx_in, par_en/par_odd -> sipo_en/sipo_din shift pulses, rx_valid with parity_err/frame_err status, busy
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic rx_tick,
  input  logic rx_in,
  input  logic par_en,
  input  logic par_odd,
  output logic sipo_en,
  output logic sipo_din,
  output logic rx_valid,
  output logic parity_err,
  output logic frame_err,
  output logic busy
);
  localparam int BW = $clog2(DATA_WIDTH);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);
  state_t state, state_n;
  logic armed, armed_n, p_en, p_en_n, p_odd, p_odd_n, par_acc, par_acc_n;
  logic perr_pend, perr_pend_n, sipo_en_n, sipo_din_n, rx_valid_n, pe_n, fe_n;
  logic [BW-1:0] bit_cnt, bit_cnt_n;
  logic decide, bit_end, bit_val;
  uart_rx_sampler #(.OVERSAMPLE(OVERSAMPLE)) u_sampler (
    .clk(clk),
    .rst(rst),
    .rx_tick(rx_tick),
    .clr(state == IDLE),
    .rx_in(rx_in),
    .decide(decide),
    .bit_end(bit_end),
    .bit_val(bit_val)
  );
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      armed <= 1'b0;
      p_en <= 1'b0;
      p_odd <= 1'b0;
      par_acc <= 1'b0;
      perr_pend <= 1'b0;
      bit_cnt <= '0;
      sipo_en <= 1'b0;
      sipo_din <= 1'b0;
      rx_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err <= 1'b0;
      busy <= 1'b0;
    end else begin
      state <= state_n;
      armed <= armed_n;
      p_en <= p_en_n;
      p_odd <= p_odd_n;
      par_acc <= par_acc_n;
      perr_pend <= perr_pend_n;
      bit_cnt <= bit_cnt_n;
      sipo_en <= sipo_en_n;
      sipo_din <= sipo_din_n;
      rx_valid <= rx_valid_n;
      parity_err <= pe_n;
      frame_err <= fe_n;
      busy <= state_n != IDLE;
    end
  end
  always_comb begin
    state_n = state;
    armed_n = armed;
    p_en_n = p_en;
    p_odd_n = p_odd;
    par_acc_n = par_acc;
    perr_pend_n = perr_pend;
    bit_cnt_n = bit_cnt;
    sipo_en_n = 1'b0;
    sipo_din_n = 1'b0;
    rx_valid_n = 1'b0;
    pe_n = parity_err;
    fe_n = frame_err;
    if (rx_tick) begin
      case (state)
        IDLE: begin
          if (rx_in) armed_n = 1'b1;
          else if (armed) begin
            state_n = START;
            armed_n = 1'b0;
            p_en_n = par_en;
            p_odd_n = par_odd;
          end
        end
        START: begin
          if (decide && bit_val) state_n = IDLE;
          else if (bit_end) begin
            state_n = DATA;
            bit_cnt_n = '0;
            par_acc_n = 1'b0;
          end
        end
        DATA: begin
          if (decide) begin
            sipo_en_n = 1'b1;
            sipo_din_n = bit_val;
            par_acc_n = par_acc ^ bit_val;
          end
          if (bit_end) begin
            if (bit_cnt == LAST_BIT) state_n = p_en ? PARITY : STOP;
            else bit_cnt_n = bit_cnt + BW'(1);
          end
        end
        PARITY: begin
          if (decide) perr_pend_n = par_acc ^ bit_val ^ p_odd;
          if (bit_end) state_n = STOP;
        end
        STOP: begin
          // leave at the stop-bit centre so the next start edge is found afresh
          if (decide) begin
            rx_valid_n = 1'b1;
            fe_n = ~bit_val;
            pe_n = p_en & perr_pend;
            armed_n = 1'b0;
            state_n = IDLE;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: directed scoreboard bench for uart_rx_ctrl
module tb_uart_rx_ctrl;
  logic clk, rst, rx_tick, rx_in, par_en, par_odd;
  logic sipo_en, sipo_din, rx_valid, parity_err, frame_err, busy;
  int total = 0;
  int bad = 0;
  int tc = 0;
  logic bq[$];
  logic [1:0] sq[$];

  uart_rx_ctrl #(.DATA_WIDTH(8), .OVERSAMPLE(16)) dut (
    .clk(clk),
    .rst(rst),
    .rx_tick(rx_tick),
    .rx_in(rx_in),
    .par_en(par_en),
    .par_odd(par_odd),
    .sipo_en(sipo_en),
    .sipo_din(sipo_din),
    .rx_valid(rx_valid),
    .parity_err(parity_err),
    .frame_err(frame_err),
    .busy(busy)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    rx_tick = 0;
    forever begin
      @(negedge clk);
      tc++;
      rx_tick = (tc % 4 == 0);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst && sipo_en) begin
      if (bq.size() == 0) chk("unexpected_sipo_en", 1, 0);
      else chk("sipo_din", sipo_din, bq.pop_front());
    end
    if (rst && rx_valid) begin
      if (sq.size() == 0) chk("unexpected_rx_valid", 1, 0);
      else chk("status_pe_fe", {parity_err, frame_err}, sq.pop_front());
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      while (!rx_tick) @(posedge clk);
    end
    #1;
  endtask

  task automatic push_frame(input logic [7:0] d, input logic pen, input logic podd,
                            input logic pbit, input logic stop);
    for (int i = 0; i < 8; i++) bq.push_back(d[i]);
    sq.push_back({pen & (^d ^ pbit ^ podd), ~stop});
  endtask

  task automatic drive_frame(input logic [7:0] d, input logic pen, input logic podd,
                             input logic pbit, input logic stop, input int gl);
    par_en = pen;
    par_odd = podd;
    rx_in = 1;
    tick(2);
    rx_in = 0;
    tick(16);
    for (int i = 0; i < 8; i++) begin
      if (i == gl) begin
        rx_in = 1;
        tick(9);
        rx_in = 0;
        tick(1);
        rx_in = 1;
        tick(6);
      end else begin
        rx_in = d[i];
        tick(16);
      end
    end
    if (pen) begin
      rx_in = pbit;
      tick(16);
    end
    rx_in = stop;
    tick(16);
    chk("busy_after_frame", busy, 0);
  endtask

  task automatic send(input logic [7:0] d, input logic pen, input logic podd,
                      input logic pbit, input logic stop, input int gl);
    push_frame(d, pen, podd, pbit, stop);
    drive_frame(d, pen, podd, pbit, stop, gl);
  endtask

  initial begin
    rst = 0;
    rx_in = 1;
    par_en = 0;
    par_odd = 0;
    repeat (3) @(negedge clk);
    chk("rst_sipo_en", sipo_en, 0);
    chk("rst_sipo_din", sipo_din, 0);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_parity_err", parity_err, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_busy", busy, 0);
    rst = 1;
    tick(3);
    send(8'hA5, 0, 0, 0, 1, -1);
    send(8'h03, 1, 0, 0, 1, -1);
    send(8'h03, 1, 0, 1, 1, -1);
    send(8'h03, 1, 1, 1, 1, -1);
    rx_in = 1;
    tick(2);
    rx_in = 0;
    tick(4);
    chk("glitch_busy_high", busy, 1);
    rx_in = 1;
    tick(8);
    chk("glitch_back_idle", busy, 0);
    tick(4);
    send(8'h3C, 0, 0, 0, 0, -1);
    rx_in = 0;
    tick(30);
    chk("break_no_start", busy, 0);
    send(8'h55, 0, 0, 0, 1, -1);
    send(8'hFF, 0, 0, 0, 1, 2);
    par_en = 0;
    rx_in = 1;
    tick(2);
    rx_in = 0;
    tick(16);
    for (int i = 0; i < 4; i++) begin
      bq.push_back(i == 0);
      rx_in = (i == 0);
      tick(16);
    end
    rx_in = 0;
    tick(5);
    chk("mid_frame_busy", busy, 1);
    rst = 0;
    rx_in = 1;
    repeat (2) @(negedge clk);
    chk("abort_sipo_en", sipo_en, 0);
    chk("abort_rx_valid", rx_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_errs", {parity_err, frame_err}, 0);
    rst = 1;
    tick(3);
    send(8'h81, 0, 0, 0, 1, -1);
    tick(4);
    chk("bits_left", bq.size(), 0);
    chk("status_left", sq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
